alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle controller directly upstream of the 8-bit ALU.
//  - Fetches two operands from the register bank and drives ALU in_A/in_B/op.
//  - Waits out the ALU's one-cycle registered result, then enables the ALU onto the shared data bus for the register-bank write.
//  - Latches the ALU flags into an architectural flags register.
// PARAMETERS
//  ADDR_W   3  register-bank address width
//  COMP_WB  1  1: comp (3'b101) result is written back; 0: comp updates flags only
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       request; sampled only in IDLE
//  op_req       in   3       ALU opcode for the request
//  src_a_sel    in   ADDR_W  register index of operand A
//  src_b_sel    in   ADDR_W  register index of operand B
//  dst_sel      in   ADDR_W  destination register index
//  busy         out  1       high from the cycle after start acceptance through WB
//  done         out  1       one-cycle pulse the cycle after WB
//  reg_rd_en    out  1       register-bank read strobe
//  reg_rd_addr  out  ADDR_W  read address
//  reg_rd_data  in   8       read data, valid one cycle after reg_rd_en
//  alu_a        out  8       to ALU in_A
//  alu_b        out  8       to ALU in_B
//  alu_op       out  3       to ALU op
//  alu_out_en   out  1       to ALU in_enable_out (bus drive enable)
//  alu_flags    in   4       from ALU flags, {C,N,O,Z}
//  reg_wr_en    out  1       register-bank write strobe; bank samples the data bus
//  reg_wr_addr  out  ADDR_W  write address
//  flags_q      out  4       registered flags, {C,N,O,Z}
// BEHAVIOUR
//  - Reset: FSM=IDLE. All outputs 0: busy, done, strobes, alu_out_en, alu_a/b/op, flags_q.
//  - Start acceptance: in IDLE with start=1, op_req, src_a_sel, src_b_sel and dst_sel are captured into op_q/a_sel_q/b_sel_q/dst_q.
//  - start outside IDLE is ignored, with no queuing.
//  - FSM states and transitions (one cycle each, no stalls):
//      IDLE    -> RD_A (start)
//      RD_A    reg_rd_en=1, reg_rd_addr=a_sel_q                      -> RD_B
//      RD_B    reg_rd_en=1, reg_rd_addr=b_sel_q; a_q<=reg_rd_data    -> LATCH_B
//      LATCH_B b_q<=reg_rd_data                                      -> EXEC
//      EXEC    alu_a=a_q, alu_b=b_q stable; ALU registers result at end of cycle -> WB
//      WB      alu_out_en=1; reg_wr_en=1 unless (op_q==comp && COMP_WB==0);
//              reg_wr_addr=dst_q; flags_q<=alu_flags at end of cycle  -> IDLE
//  - done=1 the cycle after WB (registered).
//  - Latency: start sampled at edge 0 -> done high in cycle 6. A start during the done cycle is accepted: back-to-back issue every 6 cycles.
//  - alu_a, alu_b and alu_op are registered and held at op_q/a_q/b_q until the next acceptance. ALU flags depend combinationally on op, so op must stay stable through WB.
//  - Unary ops (not, shr, shl) still perform both reads; the ALU ignores in_B. The B read is harmless.
//  - alu_out_en is high only in WB; otherwise the bus is free for other drivers.
//  - reset in any state: next cycle IDLE, no write issued, flags_q=0, done=0.
//  - Flags are not updated on reset-aborted operations, nor outside WB.
// STRUCTURE
//  - Shared package alu_pkg:
//      ALU opcode localparams ADD..SHL (3'b000..3'b111)
//      flag bit indices FLAG_C=3, FLAG_N=2, FLAG_O=1, FLAG_Z=0
//      FSM state encoding
//  - Single module, one FSM plus operand/flag registers. No sub-module.
// TESTING
//  Bench models the ALU and a registered-read register bank.
//  1. Add overflow: r1=0x7F, r2=0x01, ADD, dst r3 -> r3=0x80; flags_q=4'b0110; done in cycle 6.
//  2. Sub borrow: r1=0x00, r2=0x01, SUB -> dst=0xFF; flags_q=4'b1100.
//  3. Comp: r1=r2=0x55, COMP.
//     - COMP_WB=1 -> dst=0x01, flags_q=4'b0000.
//     - COMP_WB=0 -> reg_wr_en never asserts, flags_q updated.
//  4. Ignored start: pulse start during EXEC -> ignored; exactly one done and one write.
//  5. Reset mid-op: rst in EXEC -> reg_wr_en/alu_out_en stay 0, flags_q=0, busy=0 next cycle.
//  6. Back-to-back: start held high -> second RD_A in the cycle after done; two writes 6 cycles apart.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, flag bit positions and sequencer state encoding
package alu_pkg;

  localparam int OP_W    = 3;
  localparam int FLAGS_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND  = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR   = 3'b011;
  localparam logic [OP_W-1:0] ALU_NOT  = 3'b100;
  localparam logic [OP_W-1:0] ALU_COMP = 3'b101;
  localparam logic [OP_W-1:0] ALU_SHR  = 3'b110;
  localparam logic [OP_W-1:0] ALU_SHL  = 3'b111;

  // Flags are packed {C,N,O,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_A    = 3'd1,
    S_RD_B    = 3'd2,
    S_LATCH_B = 3'd3,
    S_EXEC    = 3'd4,
    S_WB      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, register-bank and ALU signals of the sequencer
// slave is the sequencer side; master is whatever issues requests and hosts the bank/ALU.
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int ADDR_W = 3
);
  logic               start;
  logic [OP_W-1:0]    op_req;
  logic [ADDR_W-1:0]  src_a_sel;
  logic [ADDR_W-1:0]  src_b_sel;
  logic [ADDR_W-1:0]  dst_sel;
  logic               busy;
  logic               done;
  logic               reg_rd_en;
  logic [ADDR_W-1:0]  reg_rd_addr;
  logic [7:0]         reg_rd_data;
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [OP_W-1:0]    alu_op;
  logic               alu_out_en;
  logic [FLAGS_W-1:0] alu_flags;
  logic               reg_wr_en;
  logic [ADDR_W-1:0]  reg_wr_addr;
  logic [FLAGS_W-1:0] flags_q;

  modport slave (
    input  start, op_req, src_a_sel, src_b_sel, dst_sel, reg_rd_data, alu_flags,
    output busy, done, reg_rd_en, reg_rd_addr, alu_a, alu_b, alu_op, alu_out_en,
           reg_wr_en, reg_wr_addr, flags_q
  );

  modport master (
    output start, op_req, src_a_sel, src_b_sel, dst_sel, reg_rd_data, alu_flags,
    input  busy, done, reg_rd_en, reg_rd_addr, alu_a, alu_b, alu_op, alu_out_en,
           reg_wr_en, reg_wr_addr, flags_q
  );

endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle operand fetch / execute / write-back controller for the 8-bit ALU
// One request at a time; a new start is only looked at in IDLE.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter bit COMP_WB = 1'b1
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  seq_state_e         state_q, state_d;
  logic [OP_W-1:0]    op_q;
  logic [ADDR_W-1:0]  a_sel_q, b_sel_q, dst_q;
  logic [7:0]         a_q, b_q;
  logic [FLAGS_W-1:0] flags_r_q;
  logic               done_q;

  logic               accept;
  logic               comp_no_wb;
  logic               rd_en, out_en, wr_en;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign comp_no_wb = (op_q == ALU_COMP) && !COMP_WB;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      flags_r_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_WB);
      if (accept) begin
        op_q    <= bus.op_req;
        a_sel_q <= bus.src_a_sel;
        b_sel_q <= bus.src_b_sel;
        dst_q   <= bus.dst_sel;
      end
      // Bank read data arrives one cycle after its strobe, so each operand lands a state late.
      if (state_q == S_RD_B)    a_q       <= bus.reg_rd_data;
      if (state_q == S_LATCH_B) b_q       <= bus.reg_rd_data;
      if (state_q == S_WB)      flags_r_q <= bus.alu_flags;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    out_en  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_RD_A;
      S_RD_A: begin
        rd_en   = 1'b1;
        rd_addr = a_sel_q;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        rd_en   = 1'b1;
        rd_addr = b_sel_q;
        state_d = S_LATCH_B;
      end
      S_LATCH_B: state_d = S_EXEC;
      S_EXEC:    state_d = S_WB;
      S_WB: begin
        out_en  = 1'b1;
        wr_en   = !comp_no_wb;
        wr_addr = dst_q;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.reg_rd_en   = rd_en;
  assign bus.reg_rd_addr = rd_addr;
  // Operands and opcode stay on the ALU inputs so its combinational flags hold through WB.
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_out_en  = out_en;
  assign bus.reg_wr_en   = wr_en;
  assign bus.reg_wr_addr = wr_addr;
  assign bus.flags_q     = flags_r_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench: ALU and registered-read bank models around two sequencers
// dut1 writes comp results back, dut0 does not.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if #(.ADDR_W(3)) b1 ();
  alu_sequencer_if #(.ADDR_W(3)) b0 ();

  alu_sequencer #(.ADDR_W(3), .COMP_WB(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_sequencer #(.ADDR_W(3), .COMP_WB(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [9:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    logic       ov;
    r  = 9'd0;
    ov = 1'b0;
    case (op)
      ALU_ADD: begin r = {1'b0, a} + {1'b0, b}; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      ALU_SUB: begin r = {1'b0, a} - {1'b0, b}; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      ALU_AND:  r = {1'b0, a & b};
      ALU_OR:   r = {1'b0, a | b};
      ALU_NOT:  r = {1'b0, ~a};
      ALU_COMP: r = {8'd0, (a == b)};
      ALU_SHR:  r = {2'b00, a[7:1]};
      default:  r = {1'b0, a[6:0], 1'b0};
    endcase
    return {ov, r};
  endfunction

  function automatic logic [3:0] flags_of(input logic [2:0] op, input logic [9:0] c);
    logic arith;
    arith = (op == ALU_ADD) || (op == ALU_SUB);
    return {arith & c[8], (op != ALU_COMP) & c[7], arith & c[9], (c[7:0] == 8'd0)};
  endfunction

  logic       pl_we = 1'b0;
  logic [2:0] pl_addr = 3'd0;
  logic [7:0] pl_data = 8'd0;

  logic [9:0] calc1_q = '0, calc0_q = '0;
  logic [7:0] regs1 [8];
  logic [7:0] regs0 [8];
  logic [7:0] bus1, bus0;
  int wr_cnt1 = 0, wr_cnt0 = 0, done_cnt1 = 0, wr_cyc1 = 0, prev_wr_cyc1 = 0;

  assign b1.alu_flags = flags_of(b1.alu_op, calc1_q);
  assign b0.alu_flags = flags_of(b0.alu_op, calc0_q);
  assign bus1 = b1.alu_out_en ? calc1_q[7:0] : 8'h00;
  assign bus0 = b0.alu_out_en ? calc0_q[7:0] : 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    calc1_q <= alu_calc(b1.alu_op, b1.alu_a, b1.alu_b);
    if (b1.reg_rd_en) b1.reg_rd_data <= regs1[b1.reg_rd_addr];
    if (pl_we) regs1[pl_addr] <= pl_data;
    else if (b1.reg_wr_en) begin
      regs1[b1.reg_wr_addr] <= bus1;
      wr_cnt1      <= wr_cnt1 + 1;
      prev_wr_cyc1 <= wr_cyc1;
      wr_cyc1      <= cyc;
    end
    if (b1.done) done_cnt1 <= done_cnt1 + 1;
  end

  always @(posedge clk) begin
    calc0_q <= alu_calc(b0.alu_op, b0.alu_a, b0.alu_b);
    if (b0.reg_rd_en) b0.reg_rd_data <= regs0[b0.reg_rd_addr];
    if (pl_we) regs0[pl_addr] <= pl_data;
    else if (b0.reg_wr_en) begin
      regs0[b0.reg_wr_addr] <= bus0;
      wr_cnt0 <= wr_cnt0 + 1;
    end
  end

  task automatic preload();
    logic [7:0] tab [8];
    tab = '{8'h00, 8'h7F, 8'h01, 8'h00, 8'h55, 8'h55, 8'hAA, 8'h56};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_addr = 3'(i); pl_data = tab[i];
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic drive_req(input bit sel, input logic [2:0] op, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] d);
    if (sel) begin
      b1.start = 1'b1; b1.op_req = op; b1.src_a_sel = a; b1.src_b_sel = b; b1.dst_sel = d;
    end else begin
      b0.start = 1'b1; b0.op_req = op; b0.src_a_sel = a; b0.src_b_sel = b; b0.dst_sel = d;
    end
  endtask

  // Issues one request and steps a fixed 8 cycles, reporting the cycle done was seen (-1 if never).
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, output int done_at);
    @(negedge clk);
    drive_req(sel, op, a, b, d);
    done_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin b1.start = 1'b0; b0.start = 1'b0; end
      if (done_at < 0 && (sel ? b1.done : b0.done)) done_at = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b1.busy); end
    total++; if (b1.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", b1.done); end
    total++;
    if ({b1.reg_rd_en, b1.reg_wr_en, b1.alu_out_en} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000", {b1.reg_rd_en, b1.reg_wr_en, b1.alu_out_en});
    end
    total++;
    if ({b1.alu_a, b1.alu_b, b1.alu_op} !== 19'd0) begin
      bad++; $display("FAIL reset_alu_in got=%h exp=0", {b1.alu_a, b1.alu_b, b1.alu_op});
    end
    total++; if (b1.flags_q !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", b1.flags_q); end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    int d;
    run_op(1'b1, ALU_ADD, 3'd1, 3'd2, 3'd3, d);
    total++; if (d !== 6) begin bad++; $display("FAIL add_latency got=%0d exp=6", d); end
    total++; if (regs1[3] !== 8'h80) begin bad++; $display("FAIL add_result got=%h exp=80", regs1[3]); end
    total++; if (b1.flags_q !== 4'b0110) begin bad++; $display("FAIL add_flags got=%b exp=0110", b1.flags_q); end
  endtask

  task automatic test_sub_borrow();
    int d;
    run_op(1'b1, ALU_SUB, 3'd0, 3'd2, 3'd3, d);
    total++; if (d !== 6) begin bad++; $display("FAIL sub_latency got=%0d exp=6", d); end
    total++; if (regs1[3] !== 8'hFF) begin bad++; $display("FAIL sub_result got=%h exp=FF", regs1[3]); end
    total++; if (b1.flags_q !== 4'b1100) begin bad++; $display("FAIL sub_flags got=%b exp=1100", b1.flags_q); end
  endtask

  task automatic test_comp();
    int d;
    run_op(1'b1, ALU_COMP, 3'd4, 3'd5, 3'd6, d);
    total++; if (regs1[6] !== 8'h01) begin bad++; $display("FAIL comp_wb_result got=%h exp=01", regs1[6]); end
    total++; if (b1.flags_q !== 4'b0000) begin bad++; $display("FAIL comp_wb_flags got=%b exp=0000", b1.flags_q); end
    run_op(1'b0, ALU_COMP, 3'd4, 3'd7, 3'd6, d);
    total++; if (d !== 6) begin bad++; $display("FAIL comp_nowb_latency got=%0d exp=6", d); end
    total++; if (wr_cnt0 !== 0) begin bad++; $display("FAIL comp_nowb_writes got=%0d exp=0", wr_cnt0); end
    total++; if (regs0[6] !== 8'hAA) begin bad++; $display("FAIL comp_nowb_dst got=%h exp=AA", regs0[6]); end
    total++; if (b0.flags_q !== 4'b0001) begin bad++; $display("FAIL comp_nowb_flags got=%b exp=0001", b0.flags_q); end
  endtask

  task automatic test_ignored_start();
    int w0, d0;
    w0 = wr_cnt1; d0 = done_cnt1;
    @(negedge clk);
    drive_req(1'b1, ALU_NOT, 3'd4, 3'd5, 3'd6);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) b1.start = 1'b0;
      if (i == 4) drive_req(1'b1, ALU_ADD, 3'd1, 3'd2, 3'd0);
      if (i == 5) b1.start = 1'b0;
    end
    total++; if (done_cnt1 - d0 !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt1 - d0); end
    total++; if (wr_cnt1 - w0 !== 1) begin bad++; $display("FAIL ign_write_count got=%0d exp=1", wr_cnt1 - w0); end
    total++; if (regs1[6] !== 8'hAA) begin bad++; $display("FAIL ign_not_result got=%h exp=AA", regs1[6]); end
    total++; if (regs1[0] !== 8'h00) begin bad++; $display("FAIL ign_r0_untouched got=%h exp=00", regs1[0]); end
    total++; if (b1.flags_q !== 4'b0100) begin bad++; $display("FAIL ign_flags got=%b exp=0100", b1.flags_q); end
  endtask

  task automatic test_reset_mid_op();
    int w0, d0;
    w0 = wr_cnt1; d0 = done_cnt1;
    @(negedge clk);
    drive_req(1'b1, ALU_ADD, 3'd1, 3'd2, 3'd6);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) b1.start = 1'b0;
    end
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_exec got=%b exp=1", b1.busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", b1.busy); end
    total++;
    if ({b1.reg_wr_en, b1.alu_out_en, b1.done} !== 3'b000) begin
      bad++; $display("FAIL rmid_strobes got=%b exp=000", {b1.reg_wr_en, b1.alu_out_en, b1.done});
    end
    total++; if (b1.flags_q !== 4'b0000) begin bad++; $display("FAIL rmid_flags got=%b exp=0000", b1.flags_q); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (wr_cnt1 !== w0) begin bad++; $display("FAIL rmid_no_write got=%0d exp=%0d", wr_cnt1, w0); end
    total++; if (done_cnt1 !== d0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_cnt1, d0); end
    total++; if (regs1[6] !== 8'hAA) begin bad++; $display("FAIL rmid_dst got=%h exp=AA", regs1[6]); end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    w0 = wr_cnt1; d0 = done_cnt1;
    @(negedge clk);
    drive_req(1'b1, ALU_AND, 3'd1, 3'd4, 3'd0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) begin
        total++; if (b1.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", b1.done); end
      end
    end
    total++;
    if ({b1.reg_rd_en, b1.reg_rd_addr} !== 4'b1_001) begin
      bad++; $display("FAIL b2b_second_rd_a got=%b exp=1001", {b1.reg_rd_en, b1.reg_rd_addr});
    end
    b1.start = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (wr_cnt1 - w0 !== 2) begin bad++; $display("FAIL b2b_writes got=%0d exp=2", wr_cnt1 - w0); end
    total++; if (done_cnt1 - d0 !== 2) begin bad++; $display("FAIL b2b_dones got=%0d exp=2", done_cnt1 - d0); end
    total++;
    if (wr_cyc1 - prev_wr_cyc1 !== 6) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=6", wr_cyc1 - prev_wr_cyc1);
    end
    total++; if (regs1[0] !== 8'h55) begin bad++; $display("FAIL b2b_result got=%h exp=55", regs1[0]); end
  endtask

  initial begin
    b1.start = 1'b0; b1.op_req = '0; b1.src_a_sel = '0; b1.src_b_sel = '0; b1.dst_sel = '0;
    b0.start = 1'b0; b0.op_req = '0; b0.src_a_sel = '0; b0.src_b_sel = '0; b0.dst_sel = '0;
    test_reset();
    preload();
    test_add_overflow();
    test_sub_borrow();
    test_comp();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
